// File: rtl/axi_req_pkg.sv
// Shared definitions for the AXI read-request generator.
//   req_state_t     : request FSM states (IDLE, ISSUE, DRAIN)
//   LP_BPB          : bytes per beat for the default 512-bit data path
//   LP_BURST_BYTES  : bytes per full burst for the default 64-beat burst
//   cnt_width()     : bit width able to hold 0..max_outstanding
package axi_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } req_state_t;

  localparam int LP_BPB         = 512 / 8;
  localparam int LP_BURST_BYTES = LP_BPB * 64;

  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/axi_outstanding_tracker.sv
// Up/down counter of AXI read bursts in flight.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   incr       : one AR handshake this cycle
//   decr       : one burst fully returned (rlast beat) this cycle
//   count      : bursts in flight
//   is_full    : registered, count == C_MAX_OUTSTANDING
//   is_zero    : registered, count == 0
module axi_outstanding_tracker
  import axi_req_pkg::*;
#(
  parameter int C_MAX_OUTSTANDING = 16,
  localparam int W = cnt_width(C_MAX_OUTSTANDING)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] count,
  output logic         is_full,
  output logic         is_zero
);

  logic [W-1:0] count_next;

  // Simultaneous incr and decr cancel; a retirement with nothing in
  // flight is a protocol error and the count stays at zero.
  always_comb begin
    count_next = count;
    if (incr && !decr)
      count_next = count + 1'b1;
    else if (decr && !incr && count != '0)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      is_full <= 1'b0;
      is_zero <= 1'b1;
    end else begin
      count   <= count_next;
      is_full <= (count_next == W'(C_MAX_OUTSTANDING));
      is_zero <= (count_next == '0);
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (reset)
                                  !(decr && !incr && count == '0));

endmodule

// File: rtl/axi_read_req_gen.sv
// AXI4 read-address generator: splits one contiguous transfer into
// C_BURST_LEN-beat bursts and limits bursts in flight to C_MAX_OUTSTANDING.
// Optional feature macro: AXI_READ_REQ_GEN_PERF_EN adds perf_stall_cycles.
// Ports:
//   aclk, areset               : clock, synchronous active-high reset
//   ctrl_start                 : start pulse (accepted only in IDLE)
//   ctrl_addr_offset           : burst-aligned byte start address
//   ctrl_xfer_size_in_bytes    : transfer size, multiple of bytes per beat
//   ctrl_done                  : one-cycle pulse when all bursts returned
//   busy                       : transfer in progress
//   m_axi_ar*                  : AXI read-address channel
//   rd_burst_done              : one pulse per returned rlast beat
//   outstanding                : bursts in flight
//   perf_stall_cycles          : (macro only) AR stall + throttle cycles
module axi_read_req_gen
  import axi_req_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic                                    ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]                 ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0]               ctrl_xfer_size_in_bytes,
  output logic                                    ctrl_done,
  output logic                                    busy,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]                 m_axi_araddr,
  output logic [7:0]                              m_axi_arlen,
  input  logic                                    rd_burst_done,
  output logic [cnt_width(C_MAX_OUTSTANDING)-1:0] outstanding
`ifdef AXI_READ_REQ_GEN_PERF_EN
  ,
  output logic [31:0]                             perf_stall_cycles
`endif
);

  localparam int CNT_W       = cnt_width(C_MAX_OUTSTANDING);
  localparam int BPB         = C_DATA_WIDTH / 8;
  localparam int BURST_BYTES = BPB * C_BURST_LEN;

  req_state_t                state;
  logic [C_LENGTH_WIDTH-1:0] remaining;
  logic [7:0]                last_len;
  logic [C_LENGTH_WIDTH-1:0] start_beats;
  logic [C_LENGTH_WIDTH-1:0] start_bursts;
  logic [7:0]                start_last_len;
  logic                      ar_hs;
  logic                      start_accept;
  logic                      is_full;
  logic                      is_zero;
  logic                      full_next;

  assign ar_hs        = m_axi_arvalid && m_axi_arready;
  // The done cycle is already IDLE, so a start there must be masked.
  assign start_accept = (state == IDLE) && ctrl_start && !ctrl_done;

  // Burst count rounds up; the remainder check avoids overflow near the
  // top of the length range that a "+ C_BURST_LEN - 1" would cause.
  always_comb begin
    start_beats  = ctrl_xfer_size_in_bytes / C_LENGTH_WIDTH'(BPB);
    start_bursts = start_beats / C_LENGTH_WIDTH'(C_BURST_LEN);
    if (start_beats % C_LENGTH_WIDTH'(C_BURST_LEN) != '0)
      start_bursts = start_bursts + 1'b1;
    start_last_len = 8'((start_beats - 1'b1) % C_LENGTH_WIDTH'(C_BURST_LEN));
  end

  axi_outstanding_tracker #(
    .C_MAX_OUTSTANDING(C_MAX_OUTSTANDING)
  ) u_tracker (
    .clk    (aclk),
    .reset  (areset),
    .incr   (ar_hs),
    .decr   (rd_burst_done),
    .count  (outstanding),
    .is_full(is_full),
    .is_zero(is_zero)
  );

  // arvalid is registered, so it is decided from the count the tracker
  // will hold after this edge: full blocks the next request, and a
  // retirement this cycle re-opens issue in the very next cycle.
  always_comb begin
    if (rd_burst_done && !ar_hs)
      full_next = 1'b0;
    else
      full_next = is_full ||
                  (ar_hs && !rd_burst_done && outstanding == CNT_W'(C_MAX_OUTSTANDING - 1));
  end

  // Request FSM. remaining counts bursts not yet handshaken, including
  // the one currently presented on the AR channel.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      busy          <= 1'b0;
      ctrl_done     <= 1'b0;
      remaining     <= '0;
      last_len      <= '0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_accept) begin
            m_axi_araddr <= ctrl_addr_offset;
            last_len     <= start_last_len;
            remaining    <= start_bursts;
            busy         <= 1'b1;
            if (start_beats == '0) begin
              state <= DRAIN;
            end else begin
              state         <= ISSUE;
              m_axi_arvalid <= 1'b1;
              m_axi_arlen   <= (start_bursts == C_LENGTH_WIDTH'(1)) ?
                               start_last_len : 8'(C_BURST_LEN - 1);
            end
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            remaining    <= remaining - 1'b1;
            m_axi_araddr <= m_axi_araddr + C_ADDR_WIDTH'(BURST_BYTES);
            if (remaining == C_LENGTH_WIDTH'(1)) begin
              m_axi_arvalid <= 1'b0;
              state         <= DRAIN;
            end else begin
              m_axi_arvalid <= !full_next;
              m_axi_arlen   <= (remaining == C_LENGTH_WIDTH'(2)) ?
                               last_len : 8'(C_BURST_LEN - 1);
            end
          end else if (!m_axi_arvalid) begin
            m_axi_arvalid <= !full_next;
          end
        end
        DRAIN: begin
          if (is_zero) begin
            ctrl_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_READ_REQ_GEN_PERF_EN
  logic stall;

  // In ISSUE, arvalid low only happens when throttled by the limit.
  assign stall = (m_axi_arvalid && !m_axi_arready) ||
                 (state == ISSUE && !m_axi_arvalid && is_full);

  always_ff @(posedge aclk) begin
    if (areset || start_accept)
      perf_stall_cycles <= '0;
    else if (stall && perf_stall_cycles != '1)
      perf_stall_cycles <= perf_stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_read_req_gen.sv
// Directed self-checking bench for axi_read_req_gen: a default instance
// and a second instance limited to two outstanding bursts.
module tb_axi_read_req_gen;
  import axi_req_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;

  logic        ctrl_start;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        ctrl_done, busy, arvalid, arready, rd_burst_done;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [4:0]  outstanding;

  logic        t_ctrl_start;
  logic [63:0] t_ctrl_addr_offset;
  logic [31:0] t_ctrl_xfer_size_in_bytes;
  logic        t_ctrl_done, t_busy, t_arvalid, t_arready, t_rd_burst_done;
  logic [63:0] t_araddr;
  logic [7:0]  t_arlen;
  logic [1:0]  t_outstanding;

`ifdef AXI_READ_REQ_GEN_PERF_EN
  logic [31:0] perf_stall_cycles, t_perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  axi_read_req_gen dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .ctrl_start             (ctrl_start),
    .ctrl_addr_offset       (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done              (ctrl_done),
    .busy                   (busy),
    .m_axi_arvalid          (arvalid),
    .m_axi_arready          (arready),
    .m_axi_araddr           (araddr),
    .m_axi_arlen            (arlen),
    .rd_burst_done          (rd_burst_done),
    .outstanding            (outstanding)
`ifdef AXI_READ_REQ_GEN_PERF_EN
    ,
    .perf_stall_cycles      (perf_stall_cycles)
`endif
  );

  axi_read_req_gen #(.C_MAX_OUTSTANDING(2)) dut_t (
    .aclk                   (aclk),
    .areset                 (areset),
    .ctrl_start             (t_ctrl_start),
    .ctrl_addr_offset       (t_ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(t_ctrl_xfer_size_in_bytes),
    .ctrl_done              (t_ctrl_done),
    .busy                   (t_busy),
    .m_axi_arvalid          (t_arvalid),
    .m_axi_arready          (t_arready),
    .m_axi_araddr           (t_araddr),
    .m_axi_arlen            (t_arlen),
    .rd_burst_done          (t_rd_burst_done),
    .outstanding            (t_outstanding)
`ifdef AXI_READ_REQ_GEN_PERF_EN
    ,
    .perf_stall_cycles      (t_perf_stall_cycles)
`endif
  );

  always #5 aclk = ~aclk;

  // Advance to just after the next rising edge; outputs then show the
  // new cycle and inputs set here are sampled at the following edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset                    = 1'b1;
    ctrl_start                = 1'b0;
    ctrl_addr_offset          = '0;
    ctrl_xfer_size_in_bytes   = '0;
    arready                   = 1'b0;
    rd_burst_done             = 1'b0;
    t_ctrl_start              = 1'b0;
    t_ctrl_addr_offset        = '0;
    t_ctrl_xfer_size_in_bytes = '0;
    t_arready                 = 1'b0;
    t_rd_burst_done           = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();
  endtask

  task automatic start_xfer(input logic [63:0] addr, input logic [31:0] size);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({arvalid, busy, ctrl_done} !== 3'b000 || araddr !== 64'h0 ||
        arlen !== 8'h0 || outstanding !== 5'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b done=%b addr=%h len=%0d out=%0d expected all zero",
               arvalid, busy, ctrl_done, araddr, arlen, outstanding);
    end
    total++;
    if ({t_arvalid, t_busy, t_ctrl_done} !== 3'b000 || t_outstanding !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state_t: got valid=%b busy=%b done=%b out=%0d expected all zero",
               t_arvalid, t_busy, t_ctrl_done, t_outstanding);
    end
  endtask

  task automatic test_basic();
    logic [63:0] base;
    logic [63:0] exp_addr;
    base = 64'h1000_0000;
    do_reset();
    arready = 1'b1;
    start_xfer(base, 32'd16384);
    for (int i = 0; i < 4; i++) begin
      exp_addr = base + 64'(i) * 64'(LP_BURST_BYTES);
      total++;
      if ({arvalid, busy} !== 2'b11 || araddr !== exp_addr || arlen !== 8'd63) begin
        bad++;
        $display("[TB] FAIL basic_ar%0d: got valid=%b busy=%b addr=%h len=%0d expected valid=1 busy=1 addr=%h len=63",
                 i, arvalid, busy, araddr, arlen, exp_addr);
      end
      step();
    end
    total++;
    if (arvalid !== 1'b0 || outstanding !== 5'd4) begin
      bad++;
      $display("[TB] FAIL basic_issued: got valid=%b out=%0d expected valid=0 out=4", arvalid, outstanding);
    end
    rd_burst_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (outstanding !== 5'(4 - k) || ctrl_done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL basic_retire%0d: got out=%0d done=%b expected out=%0d done=0",
                 k, outstanding, ctrl_done, 4 - k);
      end
      step();
    end
    rd_burst_done = 1'b0;
    total++;
    if (outstanding !== 5'd0 || ctrl_done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_drained: got out=%0d done=%b busy=%b expected out=0 done=0 busy=1",
               outstanding, ctrl_done, busy);
    end
    step();
    total++;
    if (ctrl_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", ctrl_done, busy);
    end
    step();
    total++;
    if (ctrl_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done_pulse: got done=%b expected 0", ctrl_done);
    end
  endtask

  task automatic test_partial_burst();
    logic [63:0] base;
    base = 64'h2000_0000;
    do_reset();
    arready = 1'b1;
    start_xfer(base, 32'd4160);
    total++;
    if (arvalid !== 1'b1 || araddr !== base || arlen !== 8'd63) begin
      bad++;
      $display("[TB] FAIL partial_first: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=63",
               arvalid, araddr, arlen, base);
    end
    step();
    total++;
    if (arvalid !== 1'b1 || araddr !== base + 64'h1000 || arlen !== 8'd0) begin
      bad++;
      $display("[TB] FAIL partial_last: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=0",
               arvalid, araddr, arlen, base + 64'h1000);
    end
    step();
    total++;
    if (arvalid !== 1'b0 || outstanding !== 5'd2) begin
      bad++;
      $display("[TB] FAIL partial_issued: got valid=%b out=%0d expected valid=0 out=2", arvalid, outstanding);
    end
    rd_burst_done = 1'b1;
    step();
    step();
    rd_burst_done = 1'b0;
    step();
    total++;
    if (ctrl_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL partial_done: got done=%b busy=%b expected done=1 busy=0", ctrl_done, busy);
    end
  endtask

  task automatic test_ar_stall();
    logic [63:0] base;
    base = 64'h3000_0000;
    do_reset();
    arready = 1'b0;
    start_xfer(base, 32'd8192);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (arvalid !== 1'b1 || araddr !== base || arlen !== 8'd63 || outstanding !== 5'd0) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b addr=%h len=%0d out=%0d expected valid=1 addr=%h len=63 out=0",
                 i, arvalid, araddr, arlen, outstanding, base);
      end
      step();
    end
    arready = 1'b1;
    step();
    total++;
    if (arvalid !== 1'b1 || araddr !== base + 64'h1000 || outstanding !== 5'd1) begin
      bad++;
      $display("[TB] FAIL stall_second: got valid=%b addr=%h out=%0d expected valid=1 addr=%h out=1",
               arvalid, araddr, outstanding, base + 64'h1000);
    end
    rd_burst_done = 1'b1;
    step();
    rd_burst_done = 1'b0;
    total++;
    if (outstanding !== 5'd1 || arvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL same_cycle_incr_decr: got out=%0d valid=%b expected out=1 valid=0",
               outstanding, arvalid);
    end
    rd_burst_done = 1'b1;
    step();
    rd_burst_done = 1'b0;
    step();
    total++;
    if (ctrl_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_done: got done=%b expected 1", ctrl_done);
    end
  endtask

  task automatic test_throttle();
    logic [63:0] base;
    base = 64'h4000_0000;
    do_reset();
    t_arready                 = 1'b1;
    t_ctrl_addr_offset        = base;
    t_ctrl_xfer_size_in_bytes = 32'd20480;
    t_ctrl_start              = 1'b1;
    step();
    t_ctrl_start = 1'b0;
    total++;
    if (t_arvalid !== 1'b1 || t_araddr !== base || t_outstanding !== 2'd0) begin
      bad++;
      $display("[TB] FAIL throttle_ar0: got valid=%b addr=%h out=%0d expected valid=1 addr=%h out=0",
               t_arvalid, t_araddr, t_outstanding, base);
    end
    step();
    total++;
    if (t_arvalid !== 1'b1 || t_araddr !== base + 64'h1000 || t_outstanding !== 2'd1) begin
      bad++;
      $display("[TB] FAIL throttle_ar1: got valid=%b addr=%h out=%0d expected valid=1 addr=%h out=1",
               t_arvalid, t_araddr, t_outstanding, base + 64'h1000);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (t_arvalid !== 1'b0 || t_outstanding !== 2'd2) begin
        bad++;
        $display("[TB] FAIL throttle_full%0d: got valid=%b out=%0d expected valid=0 out=2",
                 i, t_arvalid, t_outstanding);
      end
    end
    t_rd_burst_done = 1'b1;
    step();
    t_rd_burst_done = 1'b0;
    total++;
    if (t_arvalid !== 1'b1 || t_araddr !== base + 64'h2000 || t_outstanding !== 2'd1) begin
      bad++;
      $display("[TB] FAIL throttle_reopen: got valid=%b addr=%h out=%0d expected valid=1 addr=%h out=1",
               t_arvalid, t_araddr, t_outstanding, base + 64'h2000);
    end
    t_arready = 1'b0;
  endtask

  task automatic test_zero_size();
    do_reset();
    arready = 1'b1;
    start_xfer(64'h5000_0000, 32'd0);
    total++;
    if (busy !== 1'b1 || arvalid !== 1'b0 || ctrl_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_busy: got busy=%b valid=%b done=%b expected busy=1 valid=0 done=0",
               busy, arvalid, ctrl_done);
    end
    start_xfer(64'h6000_0000, 32'd4096);
    total++;
    if (ctrl_done !== 1'b1 || busy !== 1'b0 || arvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b valid=%b expected done=1 busy=0 valid=0",
               ctrl_done, busy, arvalid);
    end
    start_xfer(64'h7000_0000, 32'd4096);
    total++;
    if (ctrl_done !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_in_done_cycle: got done=%b busy=%b valid=%b expected done=0 busy=0 valid=0",
               ctrl_done, busy, arvalid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arready = 1'b1;
    start_xfer(64'h1000_0000, 32'd16384);
    step();
    step();
    step();
    total++;
    if (outstanding !== 5'd3 || arvalid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_pre_reset: got out=%0d valid=%b expected out=3 valid=1", outstanding, arvalid);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    total++;
    if ({arvalid, busy, ctrl_done} !== 3'b000 || araddr !== 64'h0 ||
        arlen !== 8'h0 || outstanding !== 5'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_state: got valid=%b busy=%b done=%b addr=%h len=%0d out=%0d expected all zero",
               arvalid, busy, ctrl_done, araddr, arlen, outstanding);
    end
    start_xfer(64'h8000_0000, 32'd4096);
    total++;
    if (arvalid !== 1'b1 || araddr !== 64'h8000_0000 || arlen !== 8'd63 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_restart: got valid=%b addr=%h len=%0d busy=%b expected valid=1 addr=80000000 len=63 busy=1",
               arvalid, araddr, arlen, busy);
    end
    step();
    total++;
    if (arvalid !== 1'b0 || outstanding !== 5'd1) begin
      bad++;
      $display("[TB] FAIL mid_restart_issued: got valid=%b out=%0d expected valid=0 out=1", arvalid, outstanding);
    end
    rd_burst_done = 1'b1;
    step();
    rd_burst_done = 1'b0;
    step();
    total++;
    if (ctrl_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_restart_done: got done=%b busy=%b expected done=1 busy=0", ctrl_done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_burst();
    test_ar_stall();
    test_throttle();
    test_zero_size();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
